// File: rtl/stream_mux_n.sv
// stream_mux_n: N-channel valid/ready sample multiplexer with manual or auto-scan channel selection.
// Optional macro STREAM_MUX_N_SWITCH_BLANK_EN inserts one blank SWITCH cycle whenever the channel changes.
module stream_mux_n #(
  parameter int INPUT_WIDTH = 16,
  parameter int NUM_INPUTS = 8,
  parameter int NUM_OF_SEL_BITS = 3
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [NUM_INPUTS*INPUT_WIDTH-1:0] IN_BUS,
  input  logic [NUM_INPUTS-1:0]             IN_VALID,
  output logic [NUM_INPUTS-1:0]             IN_READY,
  input  logic [NUM_OF_SEL_BITS-1:0]        SEL,
  input  logic                              MODE,
  output logic [INPUT_WIDTH-1:0]            OUT,
  output logic [NUM_OF_SEL_BITS-1:0]        OUT_CH,
  output logic                              OUT_VALID,
  input  logic                              OUT_READY,
  output logic                              SEL_ERR
);
  typedef enum logic [1:0] {
    IDLE,
    HOLD
`ifdef STREAM_MUX_N_SWITCH_BLANK_EN
    , SWITCH
`endif
  } state_t;
  localparam logic [NUM_OF_SEL_BITS-1:0] LAST = NUM_OF_SEL_BITS'(NUM_INPUTS - 1);
  state_t state;
  logic [NUM_OF_SEL_BITS-1:0] ch, eff, nxt;
  logic [INPUT_WIDTH-1:0] sample;
  logic idle, sel_ok;
  // In manual mode the idle channel follows SEL directly so IN_READY tracks it without a cycle of lag.
  always_comb begin
    idle = state == IDLE;
    sel_ok = 32'(SEL) < NUM_INPUTS;
    eff = MODE ? ch : SEL;
    nxt = MODE ? (ch == LAST ? '0 : ch + 1'b1) : (sel_ok ? SEL : ch);
    IN_READY = (idle && !RST && (MODE || sel_ok)) ? NUM_INPUTS'(1) << eff : '0;
    sample = IN_BUS[eff*INPUT_WIDTH +: INPUT_WIDTH];
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      ch <= '0;
      OUT <= '0;
      OUT_CH <= '0;
      OUT_VALID <= 1'b0;
      SEL_ERR <= 1'b0;
    end else begin
      SEL_ERR <= idle && !MODE && !sel_ok;
      case (state)
        IDLE: begin
          if (MODE || sel_ok) ch <= eff;
          if (|(IN_READY & IN_VALID)) begin
            OUT <= sample;
            OUT_CH <= eff;
            OUT_VALID <= 1'b1;
            state <= HOLD;
          end
        end
        HOLD: if (OUT_READY) begin
          OUT_VALID <= 1'b0;
          ch <= nxt;
`ifdef STREAM_MUX_N_SWITCH_BLANK_EN
          state <= nxt != ch ? SWITCH : IDLE;
`else
          state <= IDLE;
`endif
        end
`ifdef STREAM_MUX_N_SWITCH_BLANK_EN
        SWITCH: state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stream_mux_n.sv
// tb_stream_mux_n: table-driven and directed checks of stream_mux_n (8-channel and 6-channel instances).
module tb_stream_mux_n;
`ifdef STREAM_MUX_N_SWITCH_BLANK_EN
  localparam bit B = 1'b1;
`else
  localparam bit B = 1'b0;
`endif
  logic clk = 0, rst = 1;
  logic [127:0] bus;
  logic [7:0] iv, rdy;
  logic [2:0] sel, och;
  logic mode, ov, ordy, err;
  logic [15:0] out;
  logic [95:0] bus6;
  logic [5:0] iv6, rdy6;
  logic [2:0] sel6, och6;
  logic mode6, ov6, ordy6, err6;
  logic [15:0] out6;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  stream_mux_n dut (
    .CLK(clk), .RST(rst), .IN_BUS(bus), .IN_VALID(iv), .IN_READY(rdy), .SEL(sel), .MODE(mode),
    .OUT(out), .OUT_CH(och), .OUT_VALID(ov), .OUT_READY(ordy), .SEL_ERR(err)
  );
  stream_mux_n #(.NUM_INPUTS(6)) dut6 (
    .CLK(clk), .RST(rst), .IN_BUS(bus6), .IN_VALID(iv6), .IN_READY(rdy6), .SEL(sel6), .MODE(mode6),
    .OUT(out6), .OUT_CH(och6), .OUT_VALID(ov6), .OUT_READY(ordy6), .SEL_ERR(err6)
  );

  typedef struct {
    logic mode; logic [2:0] sel; logic [7:0] iv; logic ordy;
    logic [7:0] rdy; logic [15:0] out; logic [2:0] och; logic ov;
  } vec_t;
  vec_t tv[13];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_bus(input logic [15:0] base);
    for (int k = 0; k < 8; k++) bus[k*16 +: 16] = base + 16'(k);
  endtask

  initial begin
    int cnt, last;
    tv[0]  = '{1'b0, 3'd2, 8'h00, 1'b1, 8'h04, 16'h0000, 3'd0, 1'b0};
    tv[1]  = '{1'b0, 3'd2, 8'hFF, 1'b0, 8'h04, 16'h1234, 3'd2, 1'b1};
    tv[2]  = '{1'b0, 3'd5, 8'hFF, 1'b0, 8'h00, 16'h1234, 3'd2, 1'b1};
    tv[3]  = '{1'b0, 3'd5, 8'hFF, 1'b1, 8'h00, 16'h1234, 3'd2, 1'b0};
    tv[4]  = '{1'b0, 3'd5, 8'h00, 1'b1, B ? 8'h00 : 8'h20, 16'h1234, 3'd2, 1'b0};
    tv[5]  = '{1'b0, 3'd5, 8'h20, 1'b1, 8'h20, 16'h1237, 3'd5, 1'b1};
    tv[6]  = '{1'b0, 3'd5, 8'hFF, 1'b1, 8'h00, 16'h1237, 3'd5, 1'b0};
    tv[7]  = '{1'b0, 3'd5, 8'h20, 1'b1, 8'h20, 16'h1237, 3'd5, 1'b1};
    tv[8]  = '{1'b0, 3'd0, 8'hFF, 1'b1, 8'h00, 16'h1237, 3'd5, 1'b0};
    tv[9]  = '{1'b0, 3'd0, 8'h00, 1'b1, B ? 8'h00 : 8'h01, 16'h1237, 3'd5, 1'b0};
    tv[10] = '{1'b0, 3'd0, 8'h01, 1'b1, 8'h01, 16'h1232, 3'd0, 1'b1};
    tv[11] = '{1'b1, 3'd0, 8'hFF, 1'b1, 8'h00, 16'h1232, 3'd0, 1'b0};
    tv[12] = '{1'b1, 3'd0, 8'hFF, 1'b0, B ? 8'h00 : 8'h02, B ? 16'h1232 : 16'h1233, B ? 3'd0 : 3'd1, !B};
    set_bus(16'h1232);
    iv = 0; sel = 0; mode = 0; ordy = 0;
    for (int k = 0; k < 6; k++) bus6[k*16 +: 16] = 16'h00A0 + 16'(k);
    iv6 = 0; sel6 = 0; mode6 = 0; ordy6 = 1;
    step; step;
    chk("rst_in_ready", rdy, 0);
    chk("rst_out", out, 0);
    chk("rst_out_ch", och, 0);
    chk("rst_out_valid", ov, 0);
    chk("rst_sel_err", err, 0);
    rst = 0;
    for (int i = 0; i < 13; i++) begin
      mode = tv[i].mode; sel = tv[i].sel; iv = tv[i].iv; ordy = tv[i].ordy;
      #1;
      chk($sformatf("v%0d_in_ready", i), rdy, tv[i].rdy);
      step;
      chk($sformatf("v%0d_out", i), out, tv[i].out);
      chk($sformatf("v%0d_out_ch", i), och, tv[i].och);
      chk($sformatf("v%0d_out_valid", i), ov, tv[i].ov);
      chk($sformatf("v%0d_sel_err", i), err, 0);
    end
    // capture ch3, then stall with a changing bus
    rst = 1; step; rst = 0;
    mode = 0; sel = 3; iv = 8'hFF; ordy = 0;
    #1 chk("hold_cap_ready", rdy, 8'h08);
    step;
    chk("hold_cap_out", out, 16'h1235);
    chk("hold_cap_ch", och, 3);
    for (int i = 0; i < 5; i++) begin
      bus = {4{32'(i) * 32'h9E3779B9}};
      sel = 3'(i);
      #1 chk("hold_in_ready", rdy, 0);
      step;
      chk("hold_out", out, 16'h1235);
      chk("hold_out_valid", ov, 1);
      chk("hold_out_ch", och, 3);
    end
    set_bus(16'h1232);
    // reset while holding a sample
    rst = 1;
    #1 chk("rsthold_in_ready", rdy, 0);
    step;
    chk("rsthold_out", out, 0);
    chk("rsthold_out_valid", ov, 0);
    chk("rsthold_out_ch", och, 0);
    rst = 0; mode = 1; iv = 8'hFF;
    #1 chk("rsthold_ch0", rdy, 8'h01);
    step;
    chk("rsthold_recap", out, 16'h1232);
    // auto-scan with wrap
    rst = 1; step; rst = 0;
    set_bus(16'h0001);
    mode = 1; iv = 8'hFF; ordy = 1;
    last = 0;
    for (int s = 0; s < 9; s++) begin
      cnt = 0;
      do begin
        step;
        cnt++;
      end while (!ov && cnt < 10);
      chk($sformatf("scan%0d_valid", s), ov, 1);
      chk($sformatf("scan%0d_ch", s), och, s % 8);
      chk($sformatf("scan%0d_out", s), out, s % 8 + 1);
      if (s > 0) chk($sformatf("scan%0d_gap", s), cnt, B ? 3 : 2);
    end
    // fixed manual select: 2 cycles per sample in either build
    ordy = 1; mode = 0; sel = 4; iv = 8'hFF;
    rst = 1; step; rst = 0;
    step;
    chk("fix_first", out, 5);
    step; step;
    chk("fix_second_valid", ov, 1);
    chk("fix_second_ch", och, 4);
    // out-of-range select on the 6-channel instance
    rst = 1; mode = 0; iv = 0; step; rst = 0;
    sel6 = 7; mode6 = 0; iv6 = 6'h3F; ordy6 = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("oor_in_ready", rdy6, 0);
      step;
      chk("oor_sel_err", err6, 1);
      chk("oor_out_valid", ov6, 0);
      chk("oor_out", out6, 0);
    end
    sel6 = 1;
    #1 chk("oor_fix_ready", rdy6, 6'h02);
    step;
    chk("oor_fix_out", out6, 16'h00A1);
    chk("oor_fix_ch", och6, 1);
    chk("oor_fix_valid", ov6, 1);
    chk("oor_fix_err", err6, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
